// File: rtl/mod_counter_n.sv
// Modulo-N up/down counter with parallel load, ENP/ENT/RCO cascade enables,
// one-shot stop-at-terminal mode, compare match and a registered terminal pulse.
module mod_counter_n #(
   parameter int WIDTH     = 8,
   parameter int MODULUS   = 256,
   parameter int RESET_VAL = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LDn,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             UP,
   input  logic             ONESHOT,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] CMP,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             TC_PULSE,
   output logic             MATCH,
   output logic             DONE
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   typedef enum logic {RUN, STOP} state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
   logic             term;
   logic             step;

   // Out-of-range load values saturate to the top of the count range.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
      if ({1'b0, val} >= MOD_EXT)
         return MAX_Q;
      return val;
   endfunction

   assign term = UP ? (Q == MAX_Q) : (Q == '0);
   assign step = ENP & ENT & ~DONE;

   always_ff @(posedge CLK) begin
      if (RST)
         state_q <= RUN;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (!LDn)
         state_nxt = RUN;
      else if (step && term && ONESHOT)
         state_nxt = STOP;
   end

   always_comb begin
      DONE  = (state_q == STOP);
      RCO   = ENT & term & ~DONE;
      MATCH = (Q == CMP);
   end

   // Count datapath: load beats counting; a terminal step either wraps or freezes.
   always_comb begin
      q_nxt  = Q;
      tc_nxt = 1'b0;
      if (!LDn) begin
         q_nxt = clamp_load(D);
      end else if (step) begin
         tc_nxt = term;
         if (!term)
            q_nxt = UP ? Q + 1'b1 : Q - 1'b1;
         else if (!ONESHOT)
            q_nxt = UP ? '0 : MAX_Q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Q        <= RST_Q;
         TC_PULSE <= 1'b0;
      end else begin
         Q        <= q_nxt;
         TC_PULSE <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_mod_counter_n.sv
// Randomised and directed bench for mod_counter_n against a modulo-arithmetic
// reference model, plus a two-stage decimal cascade.
module tb_mod_counter_n;
   localparam int W  = 4;
   localparam int M  = 10;
   localparam int RV = 0;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic         RST, LDn, ENP, ENT, UP, ONESHOT;
   logic [W-1:0] D, CMP;
   logic [W-1:0] Q;
   logic         RCO, TC_PULSE, MATCH, DONE;

   logic         cRST, cENP;
   logic [W-1:0] q0, q1;
   logic         rco0, rco1, tc0, tc1, m0, m1, dn0, dn1;

   mod_counter_n #(.WIDTH(W), .MODULUS(M), .RESET_VAL(RV)) dut (
      .CLK(CLK), .RST(RST), .LDn(LDn), .ENP(ENP), .ENT(ENT), .UP(UP),
      .ONESHOT(ONESHOT), .D(D), .CMP(CMP), .Q(Q), .RCO(RCO),
      .TC_PULSE(TC_PULSE), .MATCH(MATCH), .DONE(DONE)
   );

   mod_counter_n #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) c0 (
      .CLK(CLK), .RST(cRST), .LDn(1'b1), .ENP(cENP), .ENT(1'b1), .UP(1'b1),
      .ONESHOT(1'b0), .D(4'd0), .CMP(4'd0), .Q(q0), .RCO(rco0),
      .TC_PULSE(tc0), .MATCH(m0), .DONE(dn0)
   );

   mod_counter_n #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) c1 (
      .CLK(CLK), .RST(cRST), .LDn(1'b1), .ENP(cENP), .ENT(rco0), .UP(1'b1),
      .ONESHOT(1'b0), .D(4'd0), .CMP(4'd0), .Q(q1), .RCO(rco1),
      .TC_PULSE(tc1), .MATCH(m1), .DONE(dn1)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Reference state: count value, one-shot stopped flag, pending pulse.
   int mq    = 0;
   int mdone = 0;
   int mtc   = 0;

   task automatic tick(input string tag);
      int term;
      int e_rco;
      term = UP ? int'(mq == M - 1) : int'(mq == 0);
      if (RST) begin
         mq = RV; mdone = 0; mtc = 0;
      end else if (!LDn) begin
         mq = (int'(D) >= M) ? M - 1 : int'(D);
         mdone = 0; mtc = 0;
      end else if (ENP && ENT && mdone == 0) begin
         mtc = term;
         if (term != 0 && ONESHOT)
            mdone = 1;
         else
            mq = (mq + (UP ? 1 : M - 1)) % M;
      end else begin
         mtc = 0;
      end
      @(posedge CLK);
      #1;
      e_rco = (ENT && mdone == 0 && (UP ? mq == M - 1 : mq == 0)) ? 1 : 0;
      chk({tag, ".Q"},     32'(Q),        mq);
      chk({tag, ".DONE"},  32'(DONE),     mdone);
      chk({tag, ".TC"},    32'(TC_PULSE), mtc);
      chk({tag, ".RCO"},   32'(RCO),      e_rco);
      chk({tag, ".MATCH"}, 32'(MATCH),    (mq == int'(CMP)) ? 1 : 0);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int seq2 [4] = '{1, 0, 9, 8};
      RST = 1'b1; LDn = 1'b1; ENP = 1'b1; ENT = 1'b1; UP = 1'b1; ONESHOT = 1'b0;
      D = '0; CMP = 4'd5; cRST = 1'b1; cENP = 1'b0;
      tick("rst"); tick("rst");
      chk("rst_q0", 32'(Q), 0);

      // Up-count wrap from reset
      RST = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick("up");
         chk("up_seq", 32'(Q), (i + 1) % 10);
      end

      // Down-count through zero
      UP = 1'b0; LDn = 1'b0; D = 4'd2;
      tick("dn_ld");
      LDn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick("dn");
         chk("dn_seq", 32'(Q), seq2[i]);
      end

      // One-shot stop and release by load
      ONESHOT = 1'b1; UP = 1'b1; LDn = 1'b0; D = 4'd7;
      tick("os_ld");
      LDn = 1'b1;
      for (int i = 0; i < 5; i++) tick("os");
      chk("os_done", 32'(DONE), 1);
      chk("os_hold", 32'(Q), 9);
      LDn = 1'b0; D = 4'd3;
      tick("os_rel");
      chk("os_clr", 32'(DONE), 0);
      LDn = 1'b1;
      tick("os_run");
      chk("os_resume", 32'(Q), 4);
      ONESHOT = 1'b0;

      // Load clamp, reset beats load, enable gating
      LDn = 1'b0; D = 4'd12;
      tick("clamp");
      chk("clamp_q", 32'(Q), 9);
      RST = 1'b1;
      tick("rst_ld");
      chk("rst_over_ld", 32'(Q), RV);
      RST = 1'b0; LDn = 1'b0; D = 4'd9;
      tick("ld9");
      LDn = 1'b1; ENT = 1'b0;
      tick("ent0"); tick("ent0");
      chk("ent0_rco", 32'(RCO), 0);
      ENP = 1'b0; ENT = 1'b1;
      tick("enp0");
      chk("enp0_rco", 32'(RCO), 1);
      ENP = 1'b1;

      // Reset during terminal pulse
      tick("wrap");
      chk("wrap_tc", 32'(TC_PULSE), 1);
      RST = 1'b1;
      tick("rst_tc");
      chk("rst_tc_clr", 32'(TC_PULSE), 0);
      RST = 1'b0;

      // Decimal cascade: the main counter idles meanwhile
      ENP = 1'b0;
      cRST = 1'b0; cENP = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge CLK);
         #1;
         chk("cas_q0", 32'(q0), n % 10);
         chk("cas_q1", 32'(q1), (n / 10) % 10);
         if (n == 99) chk("cas_rco0", 32'(rco0), 1);
         if (n == 100) begin
            chk("cas_tc0", 32'(tc0), 1);
            chk("cas_tc1", 32'(tc1), 1);
         end
      end
      cENP = 1'b0;
      ENP = 1'b1;

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         RST = ($urandom % 40) == 0;
         LDn = ($urandom % 10) != 0;
         ENP = ($urandom % 8) != 0;
         ENT = ($urandom % 8) != 0;
         if (($urandom % 20) == 0) UP = ~UP;
         if (($urandom % 30) == 0) ONESHOT = ~ONESHOT;
         D   = 4'($urandom % 16);
         CMP = 4'($urandom % 16);
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
